fb_row_loader: RTL and testbench
================================

# fb_row_loader

Parametrised framebuffer row loader between the UART receive controller and the display RAM write port. Accepts one fully received pixel row (packed pixels plus row index) via valid/ready, serialises it into per-pixel RAM writes at address `row*WIDTH + col` under write-port back-pressure, then issues a one-byte answer for the UART transmitter. Generalises the fixed 640x480, 3-bit loader to any geometry and pixel depth. Adds row-range checking, frame-completion tracking and flow control on every interface.

## Interface
- `WIDTH`, 640, pixels per row
- `HEIGHT`, 480, rows per frame
- `PIX_W`, 3, bits per pixel (palette index width)
- `ROW_W`, 9, row index width; must satisfy 2^ROW_W > HEIGHT
- `ADDR_W`, 19, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `row_valid`  in  1  row offered
- `row_ready`  out  1  loader can accept a row
- `row_idx`  in  ROW_W  target row
- `row_data`  in  WIDTH*PIX_W  pixel c in bits [c*PIX_W +: PIX_W]
- `fb_wr_en`  out  1  write request
- `fb_wr_addr`  out  ADDR_W  write address
- `fb_wr_data`  out  PIX_W  pixel value
- `fb_wr_ready`  in  1  RAM accepts the write this cycle
- `ans_valid`  out  1  answer byte valid
- `ans_data`  out  8  answer byte
- `ans_ready`  in  1  transmitter takes the byte
- `frame_done`  out  1  one-cycle pulse when the last row is written
- `rows_loaded`  out  ROW_W  good rows loaded in the current frame

## Operation
- FSM states are IDLE, WRITE and ANSWER.
- **IDLE**
  - `row_ready`=1.
  - On `row_valid & row_ready`: capture `row_data` into the shift register and `row_idx`.
  - If `row_idx >= HEIGHT`: go to ANSWER with code NAK=0xEE. No writes.
  - Otherwise: register `base = row_idx*WIDTH` (constant multiply), set `col`=0, go to WRITE.
- **WRITE**
  - `fb_wr_en`=1, `fb_wr_addr = base + col`, `fb_wr_data` = shift-register LSBs.
  - While `fb_wr_ready`=0, all three outputs hold stable.
  - On `fb_wr_ready`=1: `col`++ and shift right by PIX_W.
  - On the accepted write with `col == WIDTH-1`: go to ANSWER and increment `rows_loaded`.
  - If that row is HEIGHT-1: code is FRM=0xAF, `frame_done` pulses, and `rows_loaded` clears to 0 instead of incrementing. Otherwise code is ACK=0xAA.
- **ANSWER**
  - `ans_valid`=1 and `ans_data` hold until `ans_ready`, then go to IDLE.
- Rows may arrive in any order. Rewriting a row is allowed and increments `rows_loaded` again; no duplicate tracking.
- `row_data` and `row_idx` are sampled only at the handshake; later changes are ignored.

## Timing
- All outputs are registered.
- Reset values: `row_ready`=0 during reset, then 1 from the first cycle after deassertion. `fb_wr_en`=0, `fb_wr_addr`=0, `fb_wr_data`=0, `ans_valid`=0, `ans_data`=0, `frame_done`=0, `rows_loaded`=0, state=IDLE.
- Row accepted at cycle T:
  - `row_ready`=0 from T+1.
  - First `fb_wr_en` at T+1.
  - With `fb_wr_ready` constantly 1, the last write is at T+WIDTH and `ans_valid` rises at T+WIDTH+1.
  - `frame_done` pulses at T+WIDTH+1.
- Out-of-range row: `ans_valid` at T+1.
- Answer taken at cycle A: `row_ready`=1 at A+1. Minimum row-to-row period is WIDTH+2 cycles.
- Each write stall cycle adds exactly one cycle of latency.
- Reset mid-row: writes and the pending answer are dropped. `rows_loaded` returns to 0.
- Address arithmetic is done at ADDR_W bits and never wraps for legal rows.
- `col` is a `$clog2(WIDTH)` counter and never exceeds WIDTH-1.

## Structure
- Package `fb_loader_pkg` holds:
  - the state enum (IDLE, WRITE, ANSWER);
  - the answer constants ACK_CODE=8'hAA, FRM_CODE=8'hAF, NAK_CODE=8'hEE.
- One sub-module, `row_shift_reg`: loadable WIDTH*PIX_W shift register with load and shift enable, outputting its low PIX_W bits.
- FSM, counters and address adder live in `fb_row_loader`.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
Bench geometry: WIDTH=4, HEIGHT=3, PIX_W=3.
- Row 1, data {7,5,2,1} (pixel0=1), `fb_wr_ready`=1 -> writes (4,1), (5,2), (6,5), (7,7) on consecutive cycles, then `ans_data`=0xAA, `rows_loaded`=1.
- Rows 0, 1, 2 in sequence -> third answer is 0xAF, `frame_done` pulses once, `rows_loaded` returns to 0.
- `row_idx`=3 -> no `fb_wr_en`, `ans_data`=0xEE at T+1, `rows_loaded` unchanged.
- `fb_wr_ready` low for 2 cycles at col 2 -> address 2+base and data held stable, total latency WIDTH+3, data correct.
- `ans_ready` low for 5 cycles -> `ans_valid` and `ans_data` held, `row_ready` stays 0, a new `row_valid` is not accepted.
- `rst_n` asserted at col 1 of a row -> all outputs return to their reset values immediately; after release no answer appears and a fresh row loads normally.

Source files
------------

// File: rtl/fb_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_loader_pkg
//  Description : Shared types and answer codes for the framebuffer row loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_loader_pkg;

  // Loader control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    ANSWER = 2'd2
  } state_e;

  // Answer bytes returned to the UART transmitter
  localparam logic [7:0] ACK_CODE = 8'hAA;  // row written
  localparam logic [7:0] FRM_CODE = 8'hAF;  // row written, frame complete
  localparam logic [7:0] NAK_CODE = 8'hEE;  // row index out of range

endpackage : fb_loader_pkg
`default_nettype wire

// File: rtl/row_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : row_shift_reg
//  Description : Loadable pixel-row shift register. Shifts right by one pixel
//                per enable, zero filling, and presents the current pixel on
//                its low PIX_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_shift_reg #(
  parameter int WIDTH = 640,
  parameter int PIX_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     shift_i,
  input  logic [WIDTH*PIX_W-1:0]   data_i,
  output logic [PIX_W-1:0]         pix_o
);

  localparam int DATA_W = WIDTH * PIX_W;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Load has priority over shift; otherwise hold
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = data_q >> PIX_W;
    end
  end

  // Row storage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign pix_o = data_q[PIX_W-1:0];

endmodule : row_shift_reg
`default_nettype wire

// File: rtl/fb_row_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fb_row_loader
//  Description : Accepts a packed pixel row, writes it pixel by pixel into the
//                framebuffer at row*WIDTH+col under back-pressure, then emits
//                an ACK/FRM/NAK answer byte. Tracks rows loaded per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_row_loader
  import fb_loader_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = 3,
  parameter int ROW_W  = 9,
  parameter int ADDR_W = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [ROW_W-1:0]         row_idx,
  input  logic [WIDTH*PIX_W-1:0]   row_data,
  output logic                     fb_wr_en,
  output logic [ADDR_W-1:0]        fb_wr_addr,
  output logic [PIX_W-1:0]         fb_wr_data,
  input  logic                     fb_wr_ready,
  output logic                     ans_valid,
  output logic [7:0]               ans_data,
  input  logic                     ans_ready,
  output logic                     frame_done,
  output logic [ROW_W-1:0]         rows_loaded
);

  localparam int                COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ROW_W-1:0]  HEIGHT_R = ROW_W'(HEIGHT);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

  // --------------------------------------------------------------------------
  // Parameter legality, checked at elaboration
  // --------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_chk_width
    $error("fb_row_loader: WIDTH must be at least 1");
  end
  if (HEIGHT < 1) begin : g_chk_height
    $error("fb_row_loader: HEIGHT must be at least 1");
  end
  if (PIX_W < 1) begin : g_chk_pix
    $error("fb_row_loader: PIX_W must be at least 1");
  end
  if ((64'd1 << ROW_W) <= 64'(HEIGHT)) begin : g_chk_row_w
    $error("fb_row_loader: ROW_W too narrow for HEIGHT");
  end
  if ((64'd1 << ADDR_W) < (64'(WIDTH) * 64'(HEIGHT))) begin : g_chk_addr_w
    $error("fb_row_loader: ADDR_W too narrow for WIDTH*HEIGHT");
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              row_ready_q, row_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              ans_valid_q, ans_valid_d;
  logic [7:0]        ans_data_q, ans_data_d;
  logic              frame_done_q, frame_done_d;
  logic [ROW_W-1:0]  rows_loaded_q, rows_loaded_d;

  logic              sr_load;
  logic              sr_shift;
  logic [ADDR_W-1:0] row_base;
  logic [COL_W-1:0]  col_inc;

  // Constant-coefficient multiply; legal rows never exceed ADDR_W bits
  assign row_base = ADDR_W'(row_idx) * WIDTH_A;
  assign col_inc  = col_q + 1'b1;

  // Pixel row storage; its low bits drive the write data directly
  row_shift_reg #(
    .WIDTH (WIDTH),
    .PIX_W (PIX_W)
  ) u_row_shift_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (row_data),
    .pix_o   (fb_wr_data)
  );

  // Next-state and next-output logic for the loader FSM
  always_comb begin
    state_d       = state_q;
    row_ready_d   = row_ready_q;
    wr_en_d       = wr_en_q;
    addr_d        = addr_q;
    base_d        = base_q;
    col_d         = col_q;
    row_d         = row_q;
    ans_valid_d   = ans_valid_q;
    ans_data_d    = ans_data_q;
    frame_done_d  = 1'b0;
    rows_loaded_d = rows_loaded_q;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;

    unique case (state_q)
      IDLE: begin
        row_ready_d = 1'b1;
        if (row_valid && row_ready_q) begin
          sr_load     = 1'b1;
          row_ready_d = 1'b0;
          row_d       = row_idx;
          if (row_idx >= HEIGHT_R) begin
            state_d     = ANSWER;
            ans_valid_d = 1'b1;
            ans_data_d  = NAK_CODE;
          end else begin
            state_d = WRITE;
            base_d  = row_base;
            col_d   = '0;
            addr_d  = row_base;
            wr_en_d = 1'b1;
          end
        end
      end

      WRITE: begin
        // Outputs hold while the RAM stalls
        if (fb_wr_ready) begin
          sr_shift = 1'b1;
          if (col_q == LAST_COL) begin
            wr_en_d     = 1'b0;
            state_d     = ANSWER;
            ans_valid_d = 1'b1;
            if (row_q == LAST_ROW) begin
              ans_data_d    = FRM_CODE;
              frame_done_d  = 1'b1;
              rows_loaded_d = '0;
            end else begin
              ans_data_d    = ACK_CODE;
              rows_loaded_d = rows_loaded_q + 1'b1;
            end
          end else begin
            col_d  = col_inc;
            addr_d = base_q + ADDR_W'(col_inc);
          end
        end
      end

      ANSWER: begin
        if (ans_ready) begin
          ans_valid_d = 1'b0;
          state_d     = IDLE;
          row_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        wr_en_d     = 1'b0;
        ans_valid_d = 1'b0;
        row_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any row in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      row_ready_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      base_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      ans_valid_q   <= 1'b0;
      ans_data_q    <= '0;
      frame_done_q  <= 1'b0;
      rows_loaded_q <= '0;
    end else begin
      state_q       <= state_d;
      row_ready_q   <= row_ready_d;
      wr_en_q       <= wr_en_d;
      addr_q        <= addr_d;
      base_q        <= base_d;
      col_q         <= col_d;
      row_q         <= row_d;
      ans_valid_q   <= ans_valid_d;
      ans_data_q    <= ans_data_d;
      frame_done_q  <= frame_done_d;
      rows_loaded_q <= rows_loaded_d;
    end
  end

  assign row_ready   = row_ready_q;
  assign fb_wr_en    = wr_en_q;
  assign fb_wr_addr  = addr_q;
  assign ans_valid   = ans_valid_q;
  assign ans_data    = ans_data_q;
  assign frame_done  = frame_done_q;
  assign rows_loaded = rows_loaded_q;

endmodule : fb_row_loader
`default_nettype wire

// File: tb/tb_fb_row_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_row_loader
//  Description : Directed self-checking bench for fb_row_loader on a 4x3
//                geometry with 3-bit pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_row_loader;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int PIX_W  = 3;
  localparam int ROW_W  = 2;
  localparam int ADDR_W = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   row_valid;
  logic                   row_ready;
  logic [ROW_W-1:0]       row_idx;
  logic [WIDTH*PIX_W-1:0] row_data;
  logic                   fb_wr_en;
  logic [ADDR_W-1:0]      fb_wr_addr;
  logic [PIX_W-1:0]       fb_wr_data;
  logic                   fb_wr_ready;
  logic                   ans_valid;
  logic [7:0]             ans_data;
  logic                   ans_ready;
  logic                   frame_done;
  logic [ROW_W-1:0]       rows_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  fb_row_loader #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .PIX_W  (PIX_W),
    .ROW_W  (ROW_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_idx     (row_idx),
    .row_data    (row_data),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_data  (fb_wr_data),
    .fb_wr_ready (fb_wr_ready),
    .ans_valid   (ans_valid),
    .ans_data    (ans_data),
    .ans_ready   (ans_ready),
    .frame_done  (frame_done),
    .rows_loaded (rows_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one row; returns in the first cycle after the handshake edge
  task automatic send_row(input logic [ROW_W-1:0] idx, input logic [WIDTH*PIX_W-1:0] data);
    row_valid = 1'b1;
    row_idx   = idx;
    row_data  = data;
    tick();
    row_valid = 1'b0;
    row_idx   = 2'd0;
    row_data  = 12'hFFF;   // later changes must be ignored
  endtask

  // Expect four back-to-back writes with the RAM always ready
  task automatic expect_row(input string tag, input int base,
                            input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < WIDTH; i++) begin
      chk({tag, "_en"},   32'(fb_wr_en),   32'd1);
      chk({tag, "_addr"}, 32'(fb_wr_addr), 32'(base + i));
      chk({tag, "_data"}, 32'(fb_wr_data), 32'(e[i]));
      tick();
    end
  endtask

  // Accept the pending answer and confirm the loader reopens
  task automatic take_answer(input string tag);
    ans_ready = 1'b1;
    tick();
    ans_ready = 1'b0;
    chk({tag, "_ans_clr"}, 32'(ans_valid), 32'd0);
    chk({tag, "_rdy"},     32'(row_ready), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    row_valid   = 1'b0;
    row_idx     = '0;
    row_data    = '0;
    fb_wr_ready = 1'b1;
    ans_ready   = 1'b0;

    // ---------------- reset values ----------------
    tick();
    tick();
    chk("rst_row_ready",   32'(row_ready),   32'd0);
    chk("rst_wr_en",       32'(fb_wr_en),    32'd0);
    chk("rst_wr_addr",     32'(fb_wr_addr),  32'd0);
    chk("rst_wr_data",     32'(fb_wr_data),  32'd0);
    chk("rst_ans_valid",   32'(ans_valid),   32'd0);
    chk("rst_ans_data",    32'(ans_data),    32'd0);
    chk("rst_frame_done",  32'(frame_done),  32'd0);
    chk("rst_rows_loaded", 32'(rows_loaded), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(row_ready), 32'd1);

    // ---------------- row 1, pixels 1,2,5,7 ----------------
    send_row(2'd1, {3'd7, 3'd5, 3'd2, 3'd1});
    chk("r1_row_ready_low", 32'(row_ready), 32'd0);
    expect_row("r1", 4, 1, 2, 5, 7);
    chk("r1_ans_valid", 32'(ans_valid),   32'd1);
    chk("r1_ans_data",  32'(ans_data),    32'hAA);
    chk("r1_rows",      32'(rows_loaded), 32'd1);
    chk("r1_wr_en_off", 32'(fb_wr_en),    32'd0);
    chk("r1_frame",     32'(frame_done),  32'd0);
    take_answer("r1");

    // ---------------- rows 0,1,2 -> frame complete ----------------
    send_row(2'd0, {3'd1, 3'd2, 3'd3, 3'd4});
    expect_row("s0", 0, 4, 3, 2, 1);
    chk("s0_ans",  32'(ans_data),    32'hAA);
    chk("s0_rows", 32'(rows_loaded), 32'd2);
    take_answer("s0");

    send_row(2'd1, {3'd0, 3'd6, 3'd6, 3'd0});
    expect_row("s1", 4, 0, 6, 6, 0);
    chk("s1_ans",  32'(ans_data),    32'hAA);
    chk("s1_rows", 32'(rows_loaded), 32'd3);
    take_answer("s1");

    send_row(2'd2, {3'd5, 3'd4, 3'd3, 3'd2});
    expect_row("s2", 8, 2, 3, 4, 5);
    chk("s2_ans_valid", 32'(ans_valid),   32'd1);
    chk("s2_ans",       32'(ans_data),    32'hAF);
    chk("s2_frame_hi",  32'(frame_done),  32'd1);
    chk("s2_rows",      32'(rows_loaded), 32'd0);
    tick();
    chk("s2_frame_lo",  32'(frame_done),  32'd0);
    chk("s2_ans_hold",  32'(ans_valid),   32'd1);
    take_answer("s2");

    // ---------------- out-of-range row ----------------
    send_row(2'd3, {3'd1, 3'd1, 3'd1, 3'd1});
    chk("nak_wr_en",     32'(fb_wr_en),    32'd0);
    chk("nak_ans_valid", 32'(ans_valid),   32'd1);
    chk("nak_ans",       32'(ans_data),    32'hEE);
    chk("nak_rows",      32'(rows_loaded), 32'd0);
    chk("nak_frame",     32'(frame_done),  32'd0);
    take_answer("nak");

    // ---------------- write stall at col 2 ----------------
    send_row(2'd1, {3'd3, 3'd6, 3'd1, 3'd5});
    chk("st_c0_addr", 32'(fb_wr_addr), 32'd4);
    chk("st_c0_data", 32'(fb_wr_data), 32'd5);
    tick();
    chk("st_c1_addr", 32'(fb_wr_addr), 32'd5);
    chk("st_c1_data", 32'(fb_wr_data), 32'd1);
    tick();
    fb_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) fb_wr_ready = 1'b1;
      chk("st_c2_en",   32'(fb_wr_en),   32'd1);
      chk("st_c2_addr", 32'(fb_wr_addr), 32'd6);
      chk("st_c2_data", 32'(fb_wr_data), 32'd6);
      tick();
    end
    chk("st_c3_addr", 32'(fb_wr_addr), 32'd7);
    chk("st_c3_data", 32'(fb_wr_data), 32'd3);
    chk("st_c3_noans", 32'(ans_valid), 32'd0);
    tick();
    chk("st_ans_valid", 32'(ans_valid),   32'd1);
    chk("st_ans",       32'(ans_data),    32'hAA);
    chk("st_rows",      32'(rows_loaded), 32'd1);

    // ---------------- answer back-pressure ----------------
    row_valid = 1'b1;
    row_idx   = 2'd0;
    row_data  = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int i = 0; i < 5; i++) begin
      chk("bp_ans_valid", 32'(ans_valid), 32'd1);
      chk("bp_ans_data",  32'(ans_data),  32'hAA);
      chk("bp_row_ready", 32'(row_ready), 32'd0);
      chk("bp_wr_en",     32'(fb_wr_en),  32'd0);
      tick();
    end
    row_valid = 1'b0;
    take_answer("bp");
    tick();
    chk("bp_not_taken", 32'(fb_wr_en),    32'd0);
    chk("bp_rows",      32'(rows_loaded), 32'd1);

    // ---------------- reset mid-row ----------------
    send_row(2'd0, {3'd7, 3'd7, 3'd7, 3'd7});
    tick();
    chk("mr_c1_addr", 32'(fb_wr_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_wr_en",     32'(fb_wr_en),    32'd0);
    chk("mr_wr_addr",   32'(fb_wr_addr),  32'd0);
    chk("mr_wr_data",   32'(fb_wr_data),  32'd0);
    chk("mr_ans_valid", 32'(ans_valid),   32'd0);
    chk("mr_ans_data",  32'(ans_data),    32'd0);
    chk("mr_rows",      32'(rows_loaded), 32'd0);
    chk("mr_row_ready", 32'(row_ready),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("mr_no_ans",   32'(ans_valid), 32'd0);
      chk("mr_no_write", 32'(fb_wr_en),  32'd0);
      tick();
    end
    send_row(2'd1, {3'd2, 3'd7, 3'd0, 3'd4});
    expect_row("mr_fresh", 4, 4, 0, 7, 2);
    chk("mr_fresh_ans",  32'(ans_data),    32'hAA);
    chk("mr_fresh_rows", 32'(rows_loaded), 32'd1);
    take_answer("mr_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fb_row_loader
`default_nettype wire
